fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction-fetch front end of the pipelined core; sits directly upstream of decode and is the only agent driving the instruction memory interface. Issues one outstanding 32-bit read at a time, tolerates arbitrary memory latency, buffers fetched instructions with their PCs in a small FIFO, and handles control-flow redirects. Redirects flush the FIFO and discard any in-flight response.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h1eceb000: first fetch address after reset.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-low reset (asserted when 0).
- `imem_addr` out 32: fetch address, always 4-byte aligned.
- `imem_rmask` out 4: 4'hF while a request is active, else 4'h0.
- `imem_rdata` in 32: instruction word, valid when `imem_resp`=1.
- `imem_resp` in 1: one-cycle response strobe.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_pc` in 32: new fetch PC; bits [1:0] ignored (treated as 00).
- `out_valid` out 1: `out_inst`/`out_pc` hold a valid instruction.
- `out_ready` in 1: decode accepts this cycle.
- `out_inst` out 32: instruction word.
- `out_pc` out 32: its address.

## Operation
- FSM: REQ (request active, response kept), REQ_DROP (request active, response discarded), IDLE (no request).
- `imem_addr`/`imem_rmask` are registered. During an active request they stay stable until and including the `imem_resp` cycle. A request is never retracted.
- Issue condition: FIFO occupancy plus one in-flight request < DEPTH+1, i.e. a free slot exists for the response. Otherwise stay in IDLE with rmask=0.
- Response in REQ: push {fetch_pc, imem_rdata}; fetch_pc += 4 (32-bit wrap, 0xFFFFFFFC→0x0). Next state REQ if a slot remains after the push and pop, else IDLE.
- Redirect in IDLE: fetch_pc ← redirect_pc; request issued next cycle.
- Redirect in REQ without `imem_resp` → REQ_DROP; fetch_pc ← redirect_pc.
- Redirect in REQ with `imem_resp` same cycle: response dropped; go to REQ at redirect_pc.
- Redirect in REQ_DROP: fetch_pc ← latest redirect_pc; stay in REQ_DROP.
- Response in REQ_DROP: discarded; go to REQ at fetch_pc.
- Redirect always clears the FIFO that cycle. It has priority over a same-cycle pop and push; `out_valid`=0 the next cycle.
- Pop when `out_valid && out_ready`. Simultaneous push and pop with the FIFO full is legal; occupancy is unchanged.
- `out_valid` may not drop without a pop or redirect; `out_inst`/`out_pc` stay stable while `out_valid && !out_ready`.

## Timing
- Reset values: `imem_rmask`=0, `imem_addr`=RESET_PC, `out_valid`=0, `out_inst`=0, `out_pc`=0, FIFO empty, fetch_pc=RESET_PC, state IDLE.
- First request: `imem_rmask`=F, `imem_addr`=RESET_PC on the first edge after `rst` returns to 1.
- Request visible in cycle T, `imem_resp` in cycle T+k (k≥1). Next request is visible at T+k+1, giving one request per k+1 cycles.
- Response to `out_valid` (no bypass): one cycle, visible at T+k+1.
- Redirect in cycle R with memory idle: request at redirect_pc visible in R+1.
- `rst` asserted mid-request: everything returns to reset values next edge. A late `imem_resp` arriving after reset, before the first request, is ignored.

## Configuration
- `FETCH_BYPASS_EN` defined: if the FIFO is empty, state is REQ, `imem_resp`=1 and no redirect, `imem_rdata`/fetch_pc drive `out_*` combinationally with `out_valid`=1 that cycle. If `out_ready`=1, nothing is pushed; otherwise the word is pushed as usual.
- Undefined: `out_*` come only from the FIFO head, giving one cycle of response-to-output latency. Both builds must pass the same functional tests.

## Structure
- `fetch_pkg`: `fetch_entry_t` {pc[31:0], inst[31:0]}, FSM state enum `fetch_state_t`, and the RESET_PC default constant.
- Sub-module `fetch_fifo`:
  - DEPTH entries of `fetch_entry_t` with push, pop and flush.
  - Outputs: full, empty and count.
  - Flush has priority over push and pop.
- Top holds the FSM, fetch_pc, issue logic and bypass mux.

## Test plan
- Reset, then fixed memory latency 1 with `out_ready`=1: requests at 0x1eceb000, 0x1eceb004, …; `out_pc` increments by 4 and `out_inst` matches memory. Addr and rmask stay stable across every wait.
- `out_ready`=0 held: exactly DEPTH entries are buffered (4 at default), then `imem_rmask`=0. Raising `out_ready` drains them in order and fetch resumes.
- Redirect to 0x00001000 with a request outstanding at latency 5: that response is dropped, the next request is 0x00001000, and no pre-redirect PC reaches `out_pc`.
- Redirect coinciding with `imem_resp` and a pop: FIFO empty next cycle and the next request is redirect_pc. Repeat with two redirects during REQ_DROP: only the last PC is fetched.
- fetch_pc at 0xFFFFFFFC: the next request is 0x00000000. A redirect to 0x00000103 fetches 0x00000100.
- Random latency 1–20 with random `out_ready`/redirects: in-order, loss-free PC stream checked against a scoreboard, in both `FETCH_BYPASS_EN` builds. Bypass build shows `out_valid` in the same cycle as `imem_resp` whenever the FIFO is empty.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StReqDrop
    } fetch_state_t;

    // Fetch addresses are always word aligned; low bits of a target are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetched {pc, inst} entries. Flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  fetch_entry_t      wdata_i,
    input  logic              pop_i,
    output fetch_entry_t      head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CntW-1:0]   count_o
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    // Pointer and occupancy update; flush empties the queue in one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage has no reset; only entries below count_q are ever observed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one outstanding imem read, FIFO of fetched words,
// redirect flush. Define FETCH_BYPASS_EN to forward a response straight to out_*
// when the FIFO is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_state_t    state_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     addr_q;
    logic [3:0]      rmask_q;

    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;

    logic            resp_take;
    logic            bypass;
    logic            push;
    logic            fifo_pop;
    logic            idle_slot;
    logic            resp_slot;
    logic [31:0]     redirect_pc_al;
    logic [31:0]     fetch_pc_inc;

    assign redirect_pc_al = align_pc(redirect_pc);
    assign fetch_pc_inc   = fetch_pc_q + 32'd4;

    // A response is kept only in REQ and only when no redirect races it.
    assign resp_take = (state_q == StReq) && imem_resp && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_take && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_pop   = !fifo_empty && out_ready;
    assign push       = resp_take && !(bypass && out_ready);
    assign push_entry = '{pc: fetch_pc_q, inst: imem_rdata};

    // No push happens in IDLE, so a slot exists unless full with no pop.
    assign idle_slot = !fifo_full || fifo_pop;
    // Occupancy after this cycle's push and pop must leave room for the next response.
    assign resp_slot = (fifo_count + CntW'(push) - CntW'(fifo_pop)) < CntW'(DEPTH);

    fetch_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Fetch control: request issue, response acceptance and redirect handling.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            rmask_q    <= 4'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc_al;
                        addr_q     <= redirect_pc_al;
                        rmask_q    <= 4'hF;
                        state_q    <= StReq;
                    end else if (idle_slot) begin
                        addr_q  <= fetch_pc_q;
                        rmask_q <= 4'hF;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc_al;
                        if (imem_resp) begin
                            // Request already completed; restart immediately.
                            addr_q <= redirect_pc_al;
                        end else begin
                            // Request cannot be retracted; wait and discard its data.
                            state_q <= StReqDrop;
                        end
                    end else if (imem_resp) begin
                        fetch_pc_q <= fetch_pc_inc;
                        if (resp_slot) begin
                            addr_q <= fetch_pc_inc;
                        end else begin
                            rmask_q <= 4'h0;
                            state_q <= StIdle;
                        end
                    end
                end
                StReqDrop: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc_al;
                    end
                    // FIFO was flushed on entry and nothing pushed since, so a slot exists.
                    if (imem_resp) begin
                        addr_q  <= redirect_valid ? redirect_pc_al : fetch_pc_q;
                        state_q <= StReq;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    rmask_q <= 4'h0;
                end
            endcase
        end
    end

    assign imem_addr  = addr_q;
    assign imem_rmask = rmask_q;

    // Output mux: FIFO head first, otherwise the bypassed response if enabled.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = '0;
        if (!fifo_empty) begin
            out_valid = 1'b1;
            out_pc    = head.pc;
            out_inst  = head.inst;
        end else if (bypass) begin
            out_valid = 1'b1;
            out_pc    = fetch_pc_q;
            out_inst  = imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h1eceb000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic [31:0] rpc;
        int          lat;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs
    logic        drv_redirect = 1'b0;
    logic [31:0] drv_rpc = '0;
    logic        drv_ready = 1'b1;
    int          lat_cfg = 1;

    // Memory and scoreboard model state
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          mem_epoch = 0;
    int          epoch = 0;
    logic [31:0] next_req = RPC;
    ent_t        q[$];
    bit          new_req_seen = 1'b0;
    logic [31:0] new_req_addr = '0;
    int          req_count = 0;
    logic        s_valid = 1'b0;
    int          accepted = 0;
    bit          want_first = 1'b0;
    logic [31:0] first_acc_pc = '0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: memory model drives inputs, outputs are checked at negedge.
    task automatic tick();
        bit   resp;
        bit   kept;
        bit   exp_valid;
        bit   byp_used;
        ent_t head;
        new_req_seen = 1'b0;
        if (mem_busy) begin
            check("req_stable_mask", {28'd0, imem_rmask}, 32'hF);
            check("req_stable_addr", imem_addr, mem_addr);
        end else if (imem_rmask == 4'hF) begin
            mem_busy     = 1'b1;
            mem_addr     = imem_addr;
            mem_epoch    = epoch;
            mem_cnt      = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(20, 1));
            new_req_seen = 1'b1;
            new_req_addr = imem_addr;
            req_count++;
            check("req_addr", imem_addr, next_req);
        end
        resp           = mem_busy && (mem_cnt == 0);
        imem_resp      = resp;
        imem_rdata     = resp ? word(mem_addr) : $urandom();
        redirect_valid = drv_redirect;
        redirect_pc    = drv_rpc;
        out_ready      = drv_ready;
        @(negedge clk);
        kept      = resp && !drv_redirect && (mem_epoch == epoch);
        exp_valid = (q.size() > 0) || (BYP && kept);
        s_valid   = out_valid;
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (q.size() > 0) begin
            head = q[0];
        end else begin
            head.pc   = mem_addr;
            head.inst = word(mem_addr);
        end
        if (out_valid && exp_valid) begin
            check("out_pc", out_pc, head.pc);
            check("out_inst", out_inst, head.inst);
        end
        if (drv_redirect) begin
            q.delete();
            epoch++;
            next_req = {drv_rpc[31:2], 2'b00};
        end else begin
            byp_used = 1'b0;
            if (out_valid && exp_valid && drv_ready) begin
                accepted++;
                if (want_first) begin
                    first_acc_pc = head.pc;
                    want_first   = 1'b0;
                end
                if (q.size() > 0) void'(q.pop_front());
                else byp_used = 1'b1;
            end
            if (kept) begin
                next_req = mem_addr + 32'd4;
                if (!byp_used) begin
                    q.push_back('{pc: mem_addr, inst: word(mem_addr)});
                    check("fifo_bound", {31'd0, q.size() <= DEPTH}, 32'd1);
                end
            end
        end
        if (resp) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!new_req_seen && n < 100);
        check(name, new_req_seen ? new_req_addr : 32'hDEAD_BEEF, exp);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        drv_redirect = 1'b1;
        drv_rpc      = pc;
        tick();
        drv_redirect = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[4];
        logic [31:0] reqs[5];
        int          n;
        int          rc0;
        int          acc0;

        vecs[0] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[1] = '{32'h0000_0103, 2, 32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{32'h0000_1000, 4, 32'h0000_1000, 32'h0000_1004};
        vecs[3] = '{32'h1eceb002, 1, 32'h1eceb000, 32'h1eceb004};

        rst = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rmask", {28'd0, imem_rmask}, 32'h0);
        check("rst_addr", imem_addr, RPC);
        check("rst_out_valid", {31'd0, out_valid}, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);

        // Release reset together with a stray response that must be ignored.
        rst = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        imem_resp = 1'b0;
        #1;
        check("first_req_mask", {28'd0, imem_rmask}, 32'hF);
        check("first_req_addr", imem_addr, RPC);
        check("first_out_valid", {31'd0, out_valid}, 32'h0);

        // Latency 1 streaming.
        lat_cfg = 1; drv_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            if (new_req_seen) begin
                reqs[n] = new_req_addr;
                n++;
            end
        end
        check("stream_reqs", n, 5);
        for (int i = 0; i < n; i++) check("stream_seq", reqs[i], RPC + 32'(4 * i));
        repeat (10) tick();

        // Reset while a request is outstanding.
        lat_cfg = 8;
        n = 0;
        while (!(mem_busy && mem_cnt >= 4) && n < 40) begin tick(); n++; end
        check("sync_rst_mid", {31'd0, n < 40}, 32'd1);
        rst = 1'b0;
        tick();
        check("midrst_rmask", {28'd0, imem_rmask}, 32'h0);
        check("midrst_addr", imem_addr, RPC);
        check("midrst_valid", {31'd0, out_valid}, 32'h0);
        mem_busy = 1'b0; q.delete(); epoch++; next_req = RPC;
        rst = 1'b1;

        // Backpressure: exactly DEPTH words are buffered, then fetch stalls.
        lat_cfg = 1; drv_ready = 1'b0;
        redirect_to(32'h0000_2000);
        rc0 = req_count;
        repeat (40) tick();
        check("bp_req_count", req_count - rc0, DEPTH);
        check("bp_buffered", q.size(), DEPTH);
        check("bp_rmask", {28'd0, imem_rmask}, 32'h0);
        want_first = 1'b1; drv_ready = 1'b1;
        repeat (20) tick();
        check("bp_first_out", first_acc_pc, 32'h0000_2000);
        check("bp_resumed", {31'd0, (req_count - rc0) > DEPTH}, 32'd1);

        // Redirect with a latency-5 request outstanding.
        lat_cfg = 5;
        n = 0;
        while (!(mem_busy && mem_cnt == 3) && n < 60) begin tick(); n++; end
        check("sync_lat5", {31'd0, n < 60}, 32'd1);
        want_first = 1'b1;
        redirect_to(32'h0000_1000);
        wait_req("drop_next_req", 32'h0000_1000);
        n = 0;
        while (want_first && n < 60) begin tick(); n++; end
        check("drop_first_out", first_acc_pc, 32'h0000_1000);

        // Redirect coinciding with a response and a pop.
        lat_cfg = 3; drv_ready = 1'b0;
        n = 0;
        while (!(q.size() >= 2 && mem_busy && mem_cnt == 0) && n < 100) begin tick(); n++; end
        check("sync_coincide", {31'd0, n < 100}, 32'd1);
        drv_ready = 1'b1;
        redirect_to(32'h0000_3000);
        tick();
        check("coincide_empty", {31'd0, s_valid}, 32'h0);
        check("coincide_req", new_req_seen ? new_req_addr : 32'hDEAD_BEEF, 32'h0000_3000);

        // Several redirects while a request is being dropped: last one wins.
        lat_cfg = 6;
        n = 0;
        while (!(mem_busy && mem_cnt == 4) && n < 100) begin tick(); n++; end
        check("sync_multi", {31'd0, n < 100}, 32'd1);
        redirect_to(32'h0000_4000);
        redirect_to(32'h0000_5000);
        redirect_to(32'h0000_6008);
        wait_req("multi_redirect_req", 32'h0000_6008);

        // Redirect table: alignment and address wrap.
        for (int i = 0; i < 4; i++) begin
            lat_cfg = vecs[i].lat;
            redirect_to(vecs[i].rpc);
            wait_req("vec_req0", vecs[i].exp0);
            wait_req("vec_req1", vecs[i].exp1);
        end

        // Random latency, backpressure and redirects against the scoreboard.
        lat_cfg = 0;
        acc0 = accepted;
        for (int i = 0; i < 2000; i++) begin
            drv_ready    = ($urandom_range(99) < 70);
            drv_redirect = ($urandom_range(99) < 3);
            case ($urandom_range(2))
                0:       drv_rpc = $urandom();
                1:       drv_rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                default: drv_rpc = 32'($urandom_range(32'hFFFF));
            endcase
            tick();
        end
        drv_redirect = 1'b0;
        check("rand_progress", {31'd0, (accepted - acc0) > 40}, 32'd1);
        lat_cfg = 1; drv_ready = 1'b1;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
